// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: one single-port DEPTH x DATA_W array shared by an
// instruction fetch port (I) and a base-relative data port (D).
// Both ports are arbitrated; on a conflict the grant alternates, and the
// first conflict after reset goes to D. Read data is registered, so it
// appears one cycle after the grant.
// Optional feature macro: MEM_BOUNDS_CHECK_EN. When defined, D accesses whose
// d_addr + dbase reaches DEPTH are blocked and raise a sticky fault. When it is
// not defined, D addresses wrap modulo DEPTH and fault is tied low.
module unified_mem_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int DBASE_RST = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              base_we,
  input  logic [ADDR_W-1:0] base_wdata,
  output logic [ADDR_W-1:0] dbase,
  output logic              fault
);

  // Physical index width; DEPTH is a power of two no larger than 2^ADDR_W.
  localparam int PA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              ptr_d_r;     // 1: D wins the next conflict
  logic [ADDR_W-1:0] dbase_r;
  logic              i_valid_r;
  logic              d_valid_r;
  logic [DATA_W-1:0] i_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;

  logic              conflict_s;
  logic              grant_i_s;
  logic              grant_d_s;
  logic [ADDR_W:0]   d_sum_s;     // one extra bit so an overflow stays visible
  logic              d_oob_s;
  logic [PA_W-1:0]   i_pa_s;
  logic [PA_W-1:0]   d_pa_s;
  logic              d_wr_en_s;
  logic              d_rd_en_s;
  logic              unused_s;

  // Arbitration: a lone requester always wins; on a conflict the pointer decides.
  always_comb begin
    conflict_s = 1'b0;
    grant_d_s  = 1'b0;
    grant_i_s  = 1'b0;
    conflict_s = i_req & d_req;
    if (d_req && (!i_req || ptr_d_r)) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
    grant_i_s = i_req & ~grant_d_s;
  end

  // Address formation and the optional bounds test on the base-relative D address.
  always_comb begin
    d_sum_s = {1'b0, d_addr} + {1'b0, dbase_r};
    i_pa_s  = i_addr[PA_W-1:0];
    d_pa_s  = d_sum_s[PA_W-1:0];
`ifdef MEM_BOUNDS_CHECK_EN
    if (d_sum_s >= (ADDR_W+1)'(DEPTH)) begin
      d_oob_s = 1'b1;
    end else begin
      d_oob_s = 1'b0;
    end
`else
    d_oob_s = 1'b0;
`endif
    d_wr_en_s = grant_d_s & d_we & ~d_oob_s;
    d_rd_en_s = grant_d_s & ~d_we;
  end

  // Address bits above the physical index are intentionally ignored.
  assign unused_s = ^{d_sum_s, i_addr};

  assign i_ready = grant_i_s;
  assign d_ready = grant_d_s;
  assign i_valid = i_valid_r;
  assign d_valid = d_valid_r;
  assign i_rdata = i_rdata_r;
  assign d_rdata = d_rdata_r;
  assign dbase   = dbase_r;

  // Conflict pointer: moves only on conflict cycles, pointing at the loser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_d_r <= 1'b1;
    end else if (conflict_s) begin
      ptr_d_r <= grant_i_s;
    end else begin
      ptr_d_r <= ptr_d_r;
    end
  end

  // Data base register; a same-cycle D access still sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbase_r <= ADDR_W'(DBASE_RST);
    end else if (base_we) begin
      dbase_r <= base_wdata;
    end else begin
      dbase_r <= dbase_r;
    end
  end

  // Instruction read response; rdata holds its last value between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_valid_r <= 1'b0;
      i_rdata_r <= {DATA_W{1'b0}};
    end else begin
      i_valid_r <= grant_i_s;
      if (grant_i_s) begin
        i_rdata_r <= mem_r[i_pa_s];
      end else begin
        i_rdata_r <= i_rdata_r;
      end
    end
  end

  // Data read response; a blocked out-of-bounds read returns zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid_r <= 1'b0;
      d_rdata_r <= {DATA_W{1'b0}};
    end else begin
      d_valid_r <= d_rd_en_s;
      if (d_rd_en_s) begin
        d_rdata_r <= d_oob_s ? {DATA_W{1'b0}} : mem_r[d_pa_s];
      end else begin
        d_rdata_r <= d_rdata_r;
      end
    end
  end

  // Array write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (d_wr_en_s) begin
      mem_r[d_pa_s] <= d_wdata;
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  logic fault_r;

  // Sticky bounds fault, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_r <= 1'b0;
    end else if (grant_d_s && d_oob_s) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end

  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Self-checking bench for unified_mem_ctrl: a reference model predicts grants,
// array contents and read data; expected read data is queued when a request is
// granted and popped when the response is due one cycle later.
module tb_unified_mem_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int DBR   = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, base_we;
  logic [AW-1:0] i_addr, d_addr, base_wdata;
  logic [DW-1:0] d_wdata;
  logic          i_ready, i_valid, d_ready, d_valid, fault;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [AW-1:0] dbase;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic          ptr_d_m;
  logic [AW-1:0] dbase_m;
  logic          fault_m;
  logic [DW-1:0] i_last_m, d_last_m;
  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic          dut_gd_last;

  unified_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .DBASE_RST(DBR)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
    .base_we(base_we), .base_wdata(base_wdata), .dbase(dbase), .fault(fault)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill_val(input int a);
    return DW'((a * 37 + 11) % 256);
  endfunction

  task automatic model_reset();
    ptr_d_m  = 1'b1;
    dbase_m  = AW'(DBR);
    fault_m  = 1'b0;
    i_last_m = '0;
    d_last_m = '0;
    exp_i_q.delete();
    exp_d_q.delete();
  endtask

  task automatic check_reset_outs();
    chk("rst_i_valid", i_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_dbase", dbase, DBR);
    chk("rst_fault", fault, 0);
  endtask

  task automatic clear_in();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; base_we = 1'b0;
  endtask

  // One clock: predict at the falling edge, check responses just after the rising edge.
  task automatic tick();
    logic          gi, gd, oob;
    logic [AW:0]   sum;
    logic [AW-1:0] pa;
    logic [DW-1:0] e;
    @(negedge clk);
    gd = d_req && (!i_req || ptr_d_m);
    gi = i_req && !gd;
    dut_gd_last = d_ready;
    chk("i_ready", i_ready, gi);
    chk("d_ready", d_ready, gd);
    if (i_req && d_req) ptr_d_m = gi;
    sum = {1'b0, d_addr} + {1'b0, dbase_m};
    oob = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
    oob = (sum >= 9'd256);
`endif
    pa = sum[AW-1:0];
    if (gi) exp_i_q.push_back(mem_m[i_addr]);
    if (gd && !d_we) exp_d_q.push_back(oob ? 8'h00 : mem_m[pa]);
    if (gd && d_we && !oob) mem_m[pa] = d_wdata;
    if (gd && oob) fault_m = 1'b1;
    if (base_we) dbase_m = base_wdata;
    @(posedge clk);
    #1;
    if (exp_i_q.size() > 0) begin
      e = exp_i_q.pop_front();
      chk("i_valid", i_valid, 1);
      chk("i_rdata", i_rdata, e);
      i_last_m = e;
    end else begin
      chk("i_valid_idle", i_valid, 0);
      chk("i_rdata_hold", i_rdata, i_last_m);
    end
    if (exp_d_q.size() > 0) begin
      e = exp_d_q.pop_front();
      chk("d_valid", d_valid, 1);
      chk("d_rdata", d_rdata, e);
      d_last_m = e;
    end else begin
      chk("d_valid_idle", d_valid, 0);
      chk("d_rdata_hold", d_rdata, d_last_m);
    end
    chk("dbase", dbase, dbase_m);
    chk("fault", fault, fault_m);
  endtask

  task automatic dwr(input logic [AW-1:0] off, input logic [DW-1:0] data);
    d_req = 1'b1; d_we = 1'b1; d_addr = off; d_wdata = data;
    tick();
    clear_in();
  endtask

  task automatic drd(input logic [AW-1:0] off);
    d_req = 1'b1; d_we = 1'b0; d_addr = off;
    tick();
    clear_in();
  endtask

  task automatic ird(input logic [AW-1:0] a);
    i_req = 1'b1; i_addr = a;
    tick();
    clear_in();
  endtask

  task automatic setbase(input logic [AW-1:0] b);
    base_we = 1'b1; base_wdata = b;
    tick();
    clear_in();
  endtask

  // Main stimulus sequence.
  initial begin
    rst = 1'b0;
    clear_in();
    i_addr = '0; d_addr = '0; d_wdata = '0; base_wdata = '0;
    dut_gd_last = 1'b0;
    model_reset();
    #12;
    check_reset_outs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Offset 5 from reset base 128 lands at 133; fetch it back.
    dwr(8'd5, 8'hA5);
    ird(8'd133);
    chk("req032_rdata", i_rdata, 8'hA5);

    // Fill the whole array with known data from base 0, then restore base 128.
    setbase(8'd0);
    for (int a = 0; a < DEPTH; a++) dwr(AW'(a), fill_val(a));
    setbase(8'd128);

    // Sustained conflict: grants alternate D, I, D, I.
    i_req = 1'b1; i_addr = 8'd7;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("conf_grant_d", dut_gd_last, (k % 2 == 0) ? 1 : 0);
    end
    clear_in();

    // Base load with a same-cycle write: the write uses the old base.
    base_we = 1'b1; base_wdata = 8'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd0; d_wdata = 8'h11;
    tick();
    clear_in();
    ird(8'd128);
    chk("req034_old_base", i_rdata, 8'h11);
    drd(8'd0);
    chk("req034_new_base", d_rdata, fill_val(8'h40));

    // Wrap versus bounds check at base 250, offset 10.
    setbase(8'd0);
    dwr(8'd4, 8'h33);
    setbase(8'd250);
    dwr(8'd10, 8'h5C);
    drd(8'd10);
    ird(8'd4);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("req035_fault", fault, 1);
    chk("req035_d_rdata", d_rdata, 8'h00);
    chk("req035_i_rdata", i_rdata, 8'h33);
`else
    chk("req035_fault", fault, 0);
    chk("req035_d_rdata", d_rdata, 8'h5C);
    chk("req035_i_rdata", i_rdata, 8'h5C);
`endif

    // Mixed random traffic including occasional base reloads.
    setbase(8'd16);
    for (int n = 0; n < 60; n++) begin
      i_req   = 1'($urandom_range(0, 1));
      i_addr  = AW'($urandom_range(0, 255));
      d_req   = 1'($urandom_range(0, 1));
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = AW'($urandom_range(0, 255));
      d_wdata = DW'($urandom_range(0, 255));
      base_we = ($urandom_range(0, 9) == 0);
      base_wdata = AW'($urandom_range(0, 255));
      tick();
    end
    clear_in();

    // Reset during a granted fetch: the response is dropped, array intact.
    i_req = 1'b1; i_addr = 8'd133;
    #1;
    chk("req036_pre_grant", i_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outs();
    model_reset();
    @(posedge clk);
    #1;
    chk("req036_no_valid", i_valid, 0);
    check_reset_outs();
    clear_in();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    ird(8'd133);
    ird(8'd128);
    ird(8'd4);
    drd(8'd5);
    drd(8'd200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
